uart_tx_scheduler: RTL and testbench

Sequences the shared UartTx transmitter between two requesters: a word queue filled by core MMIO stores (send address 0xfffffff4) and single-byte sends from the DMA controller. It sits between the memory controller hub and UartTx, and is the only driver of `tx_start`/`sdata`. It buffers core words, serialises each into bytes LSB-first, and reports free queue space for the MMIO status address 0xfffffff8.

---
 rtl/uart_tx_scheduler_pkg.sv | 8 +
 rtl/uart_tx_scheduler_if.sv | 23 ++
 rtl/tx_word_fifo.sv | 37 +++
 rtl/uart_tx_scheduler.sv | 60 ++++++
 tb/tb_uart_tx_scheduler.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// uart_sched_pkg: shared FSM state and queue entry types for the UART TX scheduler
package uart_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} sched_state_t;
  typedef struct packed {
    logic        word;
    logic [31:0] data;
  } txq_entry_t;
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: core, DMA, UartTx and status signals of the TX scheduler
interface uart_tx_scheduler_if;
  logic        core_push;
  logic [31:0] core_wdata;
  logic        core_word;
  logic        dma_req;
  logic [7:0]  dma_byte;
  logic        dma_grant;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        tx_busy;
  logic [31:0] sendable;
  logic        overflow;
  logic        idle;
  modport master (
    output core_push, core_wdata, core_word, dma_req, dma_byte, tx_busy,
    input  dma_grant, tx_start, sdata, sendable, overflow, idle
  );
  modport slave (
    input  core_push, core_wdata, core_word, dma_req, dma_byte, tx_busy,
    output dma_grant, tx_start, sdata, sendable, overflow, idle
  );
endinterface

// File: rtl/tx_word_fifo.sv
// tx_word_fifo: circular word queue with occupancy count and sticky overflow
module tx_word_fifo import uart_sched_pkg::*; #(
  parameter int BUF_DEPTH = 16,
  localparam int AW = $clog2(BUF_DEPTH)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  txq_entry_t din,
  output txq_entry_t dout,
  output logic [AW:0] count,
  output logic       empty,
  output logic       overflow
);
  txq_entry_t mem [BUF_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic full, push_ok;
  assign full = count == (AW+1)'(BUF_DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign dout = mem[rptr];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      wptr <= wptr + AW'(push_ok);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      overflow <= overflow | (push && full);
    end
  always_ff @(posedge clock)
    if (push_ok) mem[wptr] <= din;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: arbitrates DMA bytes and queued core words onto the shared UartTx
module uart_tx_scheduler import uart_sched_pkg::*; #(
  parameter int BUF_DEPTH = 16
) (
  input logic clock,
  input logic reset,
  uart_tx_scheduler_if.slave bus
);
  localparam int AW = $clog2(BUF_DEPTH);
  sched_state_t state, state_n;
  txq_entry_t head, cur;
  logic [AW:0] count;
  logic empty, take_dma, take_q, next_byte;
  logic [1:0] byte_idx, nxt_idx;
  tx_word_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(bus.core_push),
    .pop(take_q),
    .din({bus.core_word, bus.core_wdata}),
    .dout(head),
    .count(count),
    .empty(empty),
    .overflow(bus.overflow)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE     ? ((take_dma || take_q) ? START : IDLE) :
              state == START    ? WAIT_ACK :
              state == WAIT_ACK ? (bus.tx_busy ? WAIT_DONE : WAIT_ACK) :
              bus.tx_busy       ? WAIT_DONE :
              next_byte         ? START : IDLE;
  always_comb begin
    take_dma = state == IDLE && !bus.tx_busy && bus.dma_req;
    take_q = state == IDLE && !bus.tx_busy && !bus.dma_req && !empty;
    next_byte = state == WAIT_DONE && !bus.tx_busy && cur.word && byte_idx != 2'd3;
    nxt_idx = byte_idx + 2'd1;
  end
  // cur.word is cleared on a DMA launch so a stale word never resumes after it
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bus.tx_start <= 1'b0;
      bus.dma_grant <= 1'b0;
      bus.sdata <= '0;
      cur <= '0;
      byte_idx <= '0;
    end else begin
      bus.tx_start <= state == START;
      bus.dma_grant <= take_dma;
      bus.sdata <= take_dma  ? bus.dma_byte :
                   take_q    ? head.data[7:0] :
                   next_byte ? cur.data[{nxt_idx, 3'b000} +: 8] : bus.sdata;
      cur <= take_dma ? '0 : take_q ? head : cur;
      byte_idx <= take_q ? 2'd0 : next_byte ? nxt_idx : byte_idx;
    end
  assign bus.idle = state == IDLE && empty && !bus.dma_req;
  assign bus.sendable = 32'(BUF_DEPTH) - 32'(count);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed self-checking bench with a simple UartTx busy model
module tb_uart_tx_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic hold_busy = 1'b0;
  int busy_cnt = 0;
  int viol = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] log_q [$];
  always #5 clock = ~clock;
  uart_tx_scheduler_if bus();
  uart_tx_scheduler #(.BUF_DEPTH(16)) dut (.clock(clock), .reset(reset), .bus(bus));
  assign bus.tx_busy = hold_busy || busy_cnt != 0;
  always @(posedge clock) begin
    busy_cnt <= bus.tx_start ? 10 : busy_cnt != 0 ? busy_cnt - 1 : 0;
    if (bus.tx_start) begin
      log_q.push_back(bus.sdata);
      if (bus.tx_busy) viol <= viol + 1;
    end
  end
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task push(input logic [31:0] d, input logic w);
    @(negedge clock);
    bus.core_push = 1'b1;
    bus.core_wdata = d;
    bus.core_word = w;
    @(negedge clock);
    bus.core_push = 1'b0;
  endtask
  task wait_idle(input int n);
    for (int i = 0; i < n && !(bus.idle && !bus.tx_busy); i++) @(negedge clock);
    check("idle_reached", 32'(bus.idle && !bus.tx_busy), 1);
  endtask
  task wait_log(input int sz, input int n);
    for (int i = 0; i < n && log_q.size() < sz; i++) @(negedge clock);
    check("log_reached", 32'(log_q.size() >= sz), 1);
  endtask
  task wait_grant(input int n);
    for (int i = 0; i < n && !bus.dma_grant; i++) @(negedge clock);
    check("grant_seen", 32'(bus.dma_grant), 1);
  endtask
  task check_reset(input string tag);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 0);
    check({tag, "_sdata"}, 32'(bus.sdata), 0);
    check({tag, "_dma_grant"}, 32'(bus.dma_grant), 0);
    check({tag, "_overflow"}, 32'(bus.overflow), 0);
    check({tag, "_idle"}, 32'(bus.idle), 1);
    check({tag, "_sendable"}, bus.sendable, 16);
  endtask
  initial begin
    bus.core_push = 1'b0;
    bus.core_wdata = '0;
    bus.core_word = 1'b0;
    bus.dma_req = 1'b0;
    bus.dma_byte = '0;
    repeat (3) @(negedge clock);
    check_reset("rst");
    reset = 1'b1;
    log_q.delete();
    push(32'h000000A5, 1'b0);
    check("byte_sendable_push", bus.sendable, 15);
    @(negedge clock);
    check("byte_sdata_load", 32'(bus.sdata), 32'hA5);
    check("byte_no_start_yet", 32'(bus.tx_start), 0);
    check("byte_sendable_pop", bus.sendable, 16);
    @(negedge clock);
    check("byte_tx_start", 32'(bus.tx_start), 1);
    wait_idle(200);
    check("byte_count", 32'(log_q.size()), 1);
    check("byte_value", 32'(log_q[0]), 32'hA5);
    log_q.delete();
    push(32'h44332211, 1'b1);
    wait_idle(500);
    check("word_count", 32'(log_q.size()), 4);
    for (int i = 0; i < 4; i++) check($sformatf("word_byte%0d", i), 32'(log_q[i]), 32'(8'h11 * (i + 1)));
    log_q.delete();
    push(32'hDDCCBBAA, 1'b1);
    wait_log(2, 200);
    bus.dma_byte = 8'h7E;
    bus.dma_req = 1'b1;
    wait_grant(500);
    check("arb_grant_after_word", 32'(log_q.size()), 4);
    check("arb_grant_sdata", 32'(bus.sdata), 32'h7E);
    bus.dma_req = 1'b0;
    wait_idle(300);
    check("arb_count", 32'(log_q.size()), 5);
    check("arb_byte3", 32'(log_q[3]), 32'hDD);
    check("arb_dma_last", 32'(log_q[4]), 32'h7E);
    log_q.delete();
    hold_busy = 1'b1;
    push(32'h00000055, 1'b0);
    bus.dma_byte = 8'h66;
    bus.dma_req = 1'b1;
    @(negedge clock);
    hold_busy = 1'b0;
    wait_grant(50);
    check("prio_queue_held", bus.sendable, 15);
    bus.dma_req = 1'b0;
    wait_idle(300);
    check("prio_count", 32'(log_q.size()), 2);
    check("prio_dma_first", 32'(log_q[0]), 32'h66);
    check("prio_queue_second", 32'(log_q[1]), 32'h55);
    log_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 20; i++) push(32'(8'h30 + i), 1'b0);
    check("full_sendable", bus.sendable, 0);
    check("full_overflow", 32'(bus.overflow), 1);
    bus.core_push = 1'b1;
    bus.core_wdata = 32'hEE;
    bus.core_word = 1'b0;
    hold_busy = 1'b0;
    @(negedge clock);
    bus.core_push = 1'b0;
    check("full_push_pop_drop", bus.sendable, 1);
    wait_idle(1000);
    check("full_count", 32'(log_q.size()), 16);
    for (int i = 0; i < 16; i++) check($sformatf("full_order%0d", i), 32'(log_q[i]), 32'(8'h30 + i));
    check("full_overflow_sticky", 32'(bus.overflow), 1);
    log_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(32'(8'h80 + i), 1'b0);
    check("five_sendable", bus.sendable, 11);
    bus.core_push = 1'b1;
    bus.core_wdata = 32'h85;
    hold_busy = 1'b0;
    @(negedge clock);
    bus.core_push = 1'b0;
    check("five_push_pop", bus.sendable, 11);
    wait_idle(1000);
    check("five_count", 32'(log_q.size()), 6);
    for (int i = 0; i < 6; i++) check($sformatf("five_order%0d", i), 32'(log_q[i]), 32'(8'h80 + i));
    log_q.delete();
    push(32'h99887766, 1'b1);
    wait_log(2, 200);
    hold_busy = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clock);
    reset = 1'b1;
    push(32'h0000003C, 1'b0);
    repeat (20) @(negedge clock);
    check("midrst_no_launch_busy", 32'(log_q.size()), 2);
    hold_busy = 1'b0;
    wait_idle(300);
    check("midrst_count", 32'(log_q.size()), 3);
    check("midrst_new_byte", 32'(log_q[2]), 32'h3C);
    check("no_start_while_busy", 32'(viol), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
